// File: rtl/datapath_seq.sv
// datapath_seq: command sequencer driving the control ports of the 16x8 register-file/ALU datapath.
// Optional `define STOP_ON_ZERO_EN: a REPEAT finishes early after the write whose ALU result is zero.
module datapath_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_alu,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic              abort,
    output logic              dp_alu_en,
    output logic              dp_write_en,
    output logic [2:0]        dp_alu_opcode,
    output logic [ADDR_W-1:0] dp_write_addr,
    output logic [ADDR_W-1:0] dp_ra_addr,
    output logic [ADDR_W-1:0] dp_rb_addr,
    output logic [DATA_W-1:0] dp_user_write_data,
    input  logic              dp_alu_zero,
    input  logic              dp_alu_carry,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic [DATA_W-1:0] iter_count
);
    typedef enum logic {IDLE, EXEC} state_t;
    localparam logic [1:0] OP_LOADI = 2'b00, OP_ALU = 2'b01, OP_REPEAT = 2'b10;
    state_t state, state_nx;
    logic [DATA_W-1:0] remaining, count_nx;
    logic is_alu, accept, start, stop_zero, finish;
    assign cmd_ready = state == IDLE;
    assign busy = state == EXEC;
    assign accept = cmd_valid && cmd_ready;
    // REPEAT with a zero count and NOP complete without ever entering EXEC
    assign start = accept && (cmd_op == OP_LOADI || cmd_op == OP_ALU || (cmd_op == OP_REPEAT && cmd_imm != '0));
    assign count_nx = iter_count + 1'b1;
`ifdef STOP_ON_ZERO_EN
    logic is_rep;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) is_rep <= 1'b0;
        else if (accept) is_rep <= cmd_op == OP_REPEAT;
    end
    assign stop_zero = is_rep && dp_alu_zero;
`else
    assign stop_zero = 1'b0;
`endif
    assign finish = busy && (count_nx == remaining || abort || stop_zero);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = start ? EXEC : finish ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_alu_en          <= 1'b0;
            dp_write_en        <= 1'b0;
            dp_alu_opcode      <= '0;
            dp_write_addr      <= '0;
            dp_ra_addr         <= '0;
            dp_rb_addr         <= '0;
            dp_user_write_data <= '0;
            done               <= 1'b0;
            aborted            <= 1'b0;
            flag_zero          <= 1'b0;
            flag_carry         <= 1'b0;
            iter_count         <= '0;
            remaining          <= '0;
            is_alu             <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (accept) begin
                iter_count    <= '0;
                dp_ra_addr    <= cmd_ra;
                dp_rb_addr    <= cmd_rb;
                dp_write_addr <= cmd_rd;
                dp_alu_opcode <= cmd_alu;
                if (cmd_op == OP_LOADI) dp_user_write_data <= cmd_imm;
                dp_alu_en     <= start && cmd_op != OP_LOADI;
                dp_write_en   <= start;
                remaining     <= cmd_op == OP_REPEAT ? cmd_imm : DATA_W'(1);
                is_alu        <= cmd_op != OP_LOADI;
                done          <= !start;
            end else if (busy) begin
                // the write at this edge always lands, so it is counted even when aborting
                iter_count <= count_nx;
                if (is_alu) begin
                    flag_zero  <= dp_alu_zero;
                    flag_carry <= dp_alu_carry;
                end
                if (finish) begin
                    dp_write_en <= 1'b0;
                    dp_alu_en   <= 1'b0;
                    done        <= 1'b1;
                    aborted     <= abort;
                end
            end
        end
    end
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: randomized scoreboard bench for datapath_seq driving a behavioural 16x8 datapath.
// Honours `define STOP_ON_ZERO_EN in its reference model.
module tb_datapath_seq;
    logic clk = 1'b0, rst = 1'b0;
    logic cmd_valid = 1'b0, abort = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [2:0] cmd_alu = '0;
    logic [3:0] cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
    logic [7:0] cmd_imm = '0;
    logic cmd_ready, dp_alu_en, dp_write_en, dp_alu_zero, dp_alu_carry;
    logic busy, done, aborted, flag_zero, flag_carry;
    logic [2:0] dp_alu_opcode;
    logic [3:0] dp_write_addr, dp_ra_addr, dp_rb_addr;
    logic [7:0] dp_user_write_data, iter_count;

    datapath_seq #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_alu(cmd_alu), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra),
        .cmd_rb(cmd_rb), .cmd_imm(cmd_imm), .abort(abort),
        .dp_alu_en(dp_alu_en), .dp_write_en(dp_write_en), .dp_alu_opcode(dp_alu_opcode),
        .dp_write_addr(dp_write_addr), .dp_ra_addr(dp_ra_addr), .dp_rb_addr(dp_rb_addr),
        .dp_user_write_data(dp_user_write_data), .dp_alu_zero(dp_alu_zero),
        .dp_alu_carry(dp_alu_carry), .busy(busy), .done(done), .aborted(aborted),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    // returns {zero, carry, result}
    function automatic logic [9:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        case (op)
            3'd0: w = {1'b0, a} + {1'b0, b};
            3'd1: w = {1'b0, a} - {1'b0, b};
            3'd2: w = {1'b0, a & b};
            3'd3: w = {1'b0, a | b};
            3'd4: w = {1'b0, a ^ b};
            3'd5: w = {1'b0, ~a};
            3'd6: w = {a, 1'b0};
            default: w = {a[0], 1'b0, a[7:1]};
        endcase
        return {w[7:0] == 8'h00, w[8], w[7:0]};
    endfunction

    // behavioural datapath the sequencer controls
    logic [7:0] regs [16];
    logic [9:0] dp_res;
    assign dp_res = alu(dp_alu_opcode, regs[dp_ra_addr], regs[dp_rb_addr]);
    assign dp_alu_zero = dp_res[9];
    assign dp_alu_carry = dp_res[8];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else if (dp_write_en && dp_write_addr != 4'd0) begin
            regs[dp_write_addr] <= dp_alu_en ? dp_res[7:0] : dp_user_write_data;
        end
    end

    int n_checks = 0, n_fail = 0;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]   iter;
        logic         z, c, ab;
        logic [127:0] rf;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] ref_regs [16];
    logic ref_z = 1'b0, ref_c = 1'b0;
    logic [127:0] env_rf;
    int cur_wr = 0, cur_busy = 0;
    logic acc_edge = 1'b0, we_edge = 1'b0;

    always @(posedge clk) begin
        acc_edge <= cmd_valid && cmd_ready;
        we_edge  <= dp_write_en;
        if (cmd_valid && cmd_ready) begin
            cur_wr   <= 0;
            cur_busy <= 0;
        end else begin
            if (dp_write_en) cur_wr <= cur_wr + 1;
            if (busy) cur_busy <= cur_busy + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (aborted && !done) begin
                n_checks++;
                n_fail++;
                $display("FAIL aborted_pulse: aborted=1 while done=0");
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 with no command outstanding");
                end else begin
                    mon_e = sb.pop_front();
                    for (int i = 0; i < 16; i++) env_rf[i*8 +: 8] = regs[i];
                    chk("iter_count", iter_count, mon_e.iter);
                    chk("write_count", cur_wr, mon_e.iter);
                    chk("busy_cycles", cur_busy, mon_e.iter);
                    chk("flag_zero", flag_zero, mon_e.z);
                    chk("flag_carry", flag_carry, mon_e.c);
                    chk("aborted", aborted, mon_e.ab);
                    chk("regfile", env_rf, mon_e.rf);
                    chk("write_en_after_done", dp_write_en, 1'b0);
                    chk("done_timing", mon_e.iter != 0 ? we_edge : acc_edge, 1'b1);
                end
            end
        end
    end

    // reference model runs the whole command at issue time, then drives it into the DUT
    task automatic issue(input logic [1:0] op, input logic [2:0] aop, input logic [3:0] rd,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [7:0] imm,
                         input int ab_at, input bit track);
        exp_t e;
        int n, i, t;
        logic [9:0] r;
        logic stop;
        n = (op == 2'd0 || op == 2'd1) ? 1 : (op == 2'd2 ? int'(imm) : 0);
        e.ab = 1'b0;
        i = 0;
        while (i < n) begin
            i++;
            r = (op == 2'd0) ? {2'b00, imm} : alu(aop, ref_regs[ra], ref_regs[rb]);
            if (rd != 4'd0) ref_regs[rd] = r[7:0];
            if (op != 2'd0) begin
                ref_z = r[9];
                ref_c = r[8];
            end
            stop = 1'b0;
`ifdef STOP_ON_ZERO_EN
            stop = op == 2'd2 && r[9];
`endif
            if (i == ab_at) begin
                e.ab = 1'b1;
                break;
            end
            if (stop) break;
        end
        e.iter = 8'(i);
        e.z = ref_z;
        e.c = ref_c;
        for (int k = 0; k < 16; k++) e.rf[k*8 +: 8] = ref_regs[k];
        if (track) sb.push_back(e);
        t = 0;
        while (!cmd_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) chk("ready_timeout", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_alu = aop;
        cmd_rd = rd;
        cmd_ra = ra;
        cmd_rb = rb;
        cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (ab_at > 0) begin
            t = 0;
            while (busy && cur_wr < ab_at - 1 && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (busy) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || !cmd_ready) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_wait", sb.size(), 0);
    endtask

    logic [1:0] r_op;
    logic [2:0] r_alu;
    logic [3:0] r_rd, r_ra, r_rb;
    logic [7:0] r_imm;
    int r_ab, w0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
        #1 rst = 1'b1;
        #1;
        chk("reset_ready", cmd_ready, 1'b1);
        chk("reset_outputs", {dp_alu_en, dp_write_en, dp_alu_opcode, dp_write_addr, dp_ra_addr,
            dp_rb_addr, dp_user_write_data, busy, done, aborted, flag_zero, flag_carry, iter_count}, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        issue(2'd0, 3'd0, 4'd3, 4'd0, 4'd0, 8'hAA, 0, 1);
        issue(2'd1, 3'd0, 4'd4, 4'd3, 4'd0, 8'h00, 0, 1);
        wait_idle();
        chk("r3", regs[3], 8'hAA);
        chk("r4", regs[4], 8'hAA);
        chk("add_flag_zero", flag_zero, 1'b0);

        issue(2'd0, 3'd0, 4'd1, 4'd0, 4'd0, 8'h00, 0, 1);
        issue(2'd0, 3'd0, 4'd2, 4'd0, 4'd0, 8'h01, 0, 1);
        issue(2'd2, 3'd0, 4'd1, 4'd1, 4'd2, 8'd64, 0, 1);
        wait_idle();
        chk("r1_rep64", regs[1], 8'h40);
        chk("iter_rep64", iter_count, 8'd64);
        chk("busy_rep64", cur_busy, 64);

        issue(2'd0, 3'd0, 4'd12, 4'd0, 4'd0, 8'd50, 0, 1);
        issue(2'd0, 3'd0, 4'd6, 4'd0, 4'd0, 8'd10, 0, 1);
        issue(2'd2, 3'd1, 4'd12, 4'd12, 4'd6, 8'd20, 0, 1);
        wait_idle();
`ifdef STOP_ON_ZERO_EN
        chk("r12_sub", regs[12], 8'h00);
        chk("iter_sub", iter_count, 8'd5);
        chk("zero_sub", flag_zero, 1'b1);
`else
        chk("r12_sub", regs[12], 8'h6A);
        chk("iter_sub", iter_count, 8'd20);
`endif

        issue(2'd2, 3'd0, 4'd5, 4'd1, 4'd2, 8'd100, 11, 1);
        wait_idle();
        chk("iter_abort", iter_count, 8'd11);
        chk("ready_after_abort", cmd_ready, 1'b1);

        issue(2'd2, 3'd0, 4'd9, 4'd1, 4'd2, 8'd0, 0, 1);
        issue(2'd3, 3'd0, 4'd9, 4'd1, 4'd2, 8'd77, 0, 1);
        wait_idle();
        chk("r9_untouched", regs[9], 8'h00);
        chk("iter_nop", iter_count, 8'd0);

        issue(2'd2, 3'd0, 4'd7, 4'd0, 4'd2, 8'd255, 0, 1);
        wait_idle();
        chk("iter_rep255", iter_count, 8'd255);

        for (int k = 0; k < 40; k++) begin
            r_op = 2'($urandom_range(0, 3));
            r_alu = 3'($urandom_range(0, 7));
            r_rd = 4'($urandom_range(0, 15));
            r_ra = 4'($urandom_range(0, 15));
            r_rb = 4'($urandom_range(0, 15));
            r_imm = (r_op == 2'd2) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
            r_ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            issue(r_op, r_alu, r_rd, r_ra, r_rb, r_imm, r_ab, 1);
        end
        wait_idle();

        issue(2'd2, 3'd0, 4'd8, 4'd8, 4'd2, 8'd100, 0, 0);
        for (int t = 0; t < 50 && cur_wr < 5; t++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_write_en", dp_write_en, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_iter", iter_count, 8'd0);
        chk("rst_flags", {flag_zero, flag_carry}, 2'b00);
        w0 = cur_wr;
        repeat (3) @(negedge clk);
        chk("rst_no_writes", cur_wr, w0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_idle_ready", cmd_ready, 1'b1);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Command sequencer that drives the control ports of the 16x8 register-file/ALU datapath.
- Accepts one command at a time over a valid/ready handshake: load-immediate, single ALU op, or ALU op repeated N times (accumulate loops).
- Registers the zero and carry flags and reports completion.
- Sits between the top-level control (host/UART/test) and the datapath. Replaces hand-sequenced stimulus of alu_en/write_en/addresses.

Parameters:
- DATA_W, 8, datapath word width; also the width of cmd_imm and iter_count.
- ADDR_W, 4, register address width (16 registers; reg0 reads as zero, writes to it are ignored by the datapath).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command; equals (state==IDLE)
- cmd_op  in  2  00 LOADI, 01 ALU, 10 REPEAT, 11 NOP
- cmd_alu  in  3  ALU opcode: ADD 000, SUB 001, AND 010, OR 011, XOR 100, NOT 101, SHL 110, SHR 111
- cmd_rd / cmd_ra / cmd_rb  in  ADDR_W each  destination / operand A / operand B register
- cmd_imm  in  DATA_W  immediate data for LOADI; iteration count for REPEAT
- abort  in  1  terminate a running command
- dp_alu_en, dp_write_en  out  1 each  to datapath
- dp_alu_opcode  out  3  to datapath
- dp_write_addr, dp_ra_addr, dp_rb_addr  out  ADDR_W each  to datapath
- dp_user_write_data  out  DATA_W  to datapath
- dp_alu_zero, dp_alu_carry  in  1 each  combinational flags from datapath
- busy  out  1  state==EXEC
- done  out  1  one-cycle completion pulse
- aborted  out  1  one-cycle pulse coincident with done when the command was aborted
- flag_zero, flag_carry  out  1 each  sticky copy of the last sampled ALU flags
- iter_count  out  DATA_W  writes completed by the current or last command

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: all outputs 0 except cmd_ready=1. State is IDLE.
- Reset mid-EXEC: dp_write_en drops immediately, so no write occurs at the next edge.
- All dp_* outputs, done, aborted, flags and iter_count are registered.
- States: IDLE and EXEC.
- Command acceptance at edge T0 (cmd_valid & cmd_ready):
  - Latch the command.
  - iter_count <= 0.
  - dp_ra_addr <= cmd_ra, dp_rb_addr <= cmd_rb, dp_write_addr <= cmd_rd, dp_alu_opcode <= cmd_alu.
- Per-op behaviour on acceptance:
  - LOADI: dp_user_write_data <= cmd_imm, dp_alu_en <= 0, dp_write_en <= 1, go to EXEC.
  - ALU: dp_alu_en <= 1, dp_write_en <= 1, go to EXEC. Remaining count = 1.
  - REPEAT with cmd_imm>0: as ALU, but remaining count = cmd_imm.
  - REPEAT with cmd_imm==0, or NOP: no write; stay IDLE; done pulses in the cycle after T0.
- EXEC, every edge:
  - The datapath performs one write; iter_count increments.
  - For ALU/REPEAT, flag_zero <= dp_alu_zero and flag_carry <= dp_alu_carry. LOADI leaves the flags unchanged.
- Completion:
  - At the edge where the write count reaches the remaining count: dp_write_en <= 0, dp_alu_en <= 0, go to IDLE, done <= 1 for one cycle.
  - A single LOADI/ALU writes at T0+1 and done is high in the following cycle.
  - A REPEAT of N writes at T0+1..T0+N.
- abort:
  - Sampled at the edge in EXEC. The write at that edge still occurs and counts; the datapath cannot cancel it.
  - Then go to IDLE with done=1 and aborted=1.
  - Ignored in IDLE, including when it coincides with cmd_valid: the command is accepted.
- cmd_valid while busy: held off (cmd_ready=0). The command fields must stay stable until accepted.
- Counter wrap-around: N=255 is the maximum; iter_count must not wrap.
- Throughput: one single-write command every 2 cycles.

Optional Feature:
- STOP_ON_ZERO_EN
- Defined: a REPEAT ends early after the write at which dp_alu_zero=1. The command goes to IDLE with done=1 and aborted=0. iter_count shows the writes actually done.
- Undefined: REPEAT always performs cmd_imm writes regardless of flags.

Test Plan:
- LOADI rd=3 imm=0xAA, then ALU ADD ra=3 rb=0 rd=4 -> r3=0xAA, r4=0xAA; flag_zero=0; each done pulse appears 1 cycle after its write edge.
- LOADI r1=0x00, LOADI r2=0x01, REPEAT ADD ra=1 rb=2 rd=1 imm=64 -> r1=0x40, iter_count=64, busy for exactly 64 cycles, a single done pulse.
- LOADI r12=50, r6=10, REPEAT SUB ra=12 rb=6 rd=12 imm=20:
  - With STOP_ON_ZERO_EN: r12=0x00, iter_count=5, flag_zero=1.
  - Without: r12=0x6A, iter_count=20.
- REPEAT ADD imm=100, assert abort for 1 cycle after the 10th write edge -> iter_count=11, done=1 and aborted=1 for the same cycle, cmd_ready=1 afterwards.
- REPEAT imm=0 and NOP -> no dp_write_en, done pulse 1 cycle after acceptance, registers unchanged.
- Assert rst asynchronously mid-REPEAT -> dp_write_en=0 immediately, no further writes, cmd_ready=1, all flags and iter_count=0.
